// File: rtl/softmax_stream_tx_if.sv
// softmax_stream_tx_if
//   Bundles the buffer-write port, the transmit request and the stream
//   toward the softmax consumer into one interface.
//   master : the side that loads the buffer and requests transmission
//   slave  : the softmax_stream_tx block itself
// Signals
//   wr_en/wr_addr/wr_data : buffer write strobe, address and IEEE-754 word
//   go/count              : transmit request and element count (sampled with go)
//   start/datain/n        : stream valid, stream word, latched element count
//   busy/done/wr_err      : not-idle, end-of-transmission pulse, sticky write error
interface softmax_stream_tx_if #(
  parameter int DATALENGTH = 32,
  parameter int INPUTMAX   = 5
);
  logic                  wr_en;
  logic [INPUTMAX-1:0]   wr_addr;
  logic [DATALENGTH-1:0] wr_data;
  logic                  go;
  logic [INPUTMAX-1:0]   count;
  logic                  start;
  logic [DATALENGTH-1:0] datain;
  logic [INPUTMAX-1:0]   n;
  logic                  busy;
  logic                  done;
  logic                  wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, go, count,
    input  start, datain, n, busy, done, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, go, count,
    output start, datain, n, busy, done, wr_err
  );
endinterface

// File: rtl/softmax_stream_tx.sv
// softmax_stream_tx
//   Holds a 2^INPUTMAX x DATALENGTH buffer of float words and, on request,
//   streams the first `count` words to a softmax consumer, one per cycle.
// Ports
//   i_clock : single clock, rising edge
//   i_reset : synchronous, active-high reset (buffer contents are kept)
//   io_bus  : softmax_stream_tx_if slave modport (write port, go/count,
//             start/datain/n stream, busy/done/wr_err status)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | buffer writable, waiting for go
// STREAM | one prefetch cycle, then one word per cycle until n words sent
// FINISH | single cycle, done=1, start=0, then back to IDLE
module softmax_stream_tx #(
  parameter int DATALENGTH = 32,
  parameter int INPUTMAX   = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  softmax_stream_tx_if.slave   io_bus
);

  localparam int DEPTH = 2 ** INPUTMAX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATALENGTH-1:0] r_mem [0:DEPTH-1];
  logic [INPUTMAX-1:0]   r_idx;
  logic [INPUTMAX-1:0]   w_idx_nxt;
  logic [INPUTMAX-1:0]   r_n;
  logic [INPUTMAX-1:0]   w_n_nxt;
  logic                  r_start;
  logic                  w_start_nxt;
  logic [DATALENGTH-1:0] r_datain;
  logic [DATALENGTH-1:0] w_datain_nxt;
  logic                  r_wr_err;
  logic                  w_wr_err_nxt;
  logic                  w_mem_we;
  logic                  w_busy;

  assign w_busy = (r_state != IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_n_nxt      = r_n;
    w_start_nxt  = 1'b0;
    w_datain_nxt = '0;
    w_mem_we     = 1'b0;
    w_wr_err_nxt = r_wr_err | (io_bus.wr_en & w_busy);

    case (r_state)
      IDLE: begin
        w_mem_we = io_bus.wr_en;
        if (io_bus.go) begin
          w_n_nxt   = io_bus.count;
          w_idx_nxt = '0;
          if (io_bus.count == '0) w_state_nxt = FINISH;
          else                    w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        // idx runs 0..n; n never exceeds 2^INPUTMAX-1 so idx never wraps.
        // The registered start/datain lag by one edge, which gives the
        // prefetch cycle after go and keeps the same-edge write visible.
        if (r_idx != r_n) begin
          w_start_nxt  = 1'b1;
          w_datain_nxt = r_mem[r_idx];
          w_idx_nxt    = r_idx + 1'b1;
        end else begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_n      <= '0;
      r_start  <= 1'b0;
      r_datain <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_n      <= w_n_nxt;
      r_start  <= w_start_nxt;
      r_datain <= w_datain_nxt;
      r_wr_err <= w_wr_err_nxt;
    end
  end

  // Buffer survives reset; reset only blocks a write on the same edge.
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_mem_we) begin
      r_mem[io_bus.wr_addr] <= io_bus.wr_data;
    end
  end

  assign io_bus.start  = r_start;
  assign io_bus.datain = r_datain;
  assign io_bus.n      = r_n;
  assign io_bus.busy   = w_busy;
  assign io_bus.done   = (r_state == FINISH);
  assign io_bus.wr_err = r_wr_err;

endmodule

// File: tb/tb_softmax_stream_tx.sv
module tb_softmax_stream_tx;
  localparam int DL    = 32;
  localparam int IM    = 5;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [DL-1:0] mdl_mem [0:DEPTH-1];

  softmax_stream_tx_if #(.DATALENGTH(DL), .INPUTMAX(IM)) bus ();

  softmax_stream_tx #(.DATALENGTH(DL), .INPUTMAX(IM)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [DL-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = IM'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
    mdl_mem[addr] = data;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".start"},  {31'd0, bus.start}, 32'd0);
    chk({tag, ".datain"}, bus.datain, 32'd0);
    chk({tag, ".n"},      {27'd0, bus.n}, 32'd0);
    chk({tag, ".busy"},   {31'd0, bus.busy}, 32'd0);
    chk({tag, ".done"},   {31'd0, bus.done}, 32'd0);
  endtask

  // Issue go with cnt and follow the whole transmission cycle by cycle.
  // Optional same-edge write (wr_now) and an illegal go+write injected at
  // cycle inj while busy (inj < 0 disables).
  task automatic run_stream(input string tag, input int cnt, input bit wr_now,
                            input int wa, input logic [DL-1:0] wd, input int inj);
    int last;
    bit exp_start, exp_done, exp_busy;
    logic [DL-1:0] exp_data;
    bus.go    = 1'b1;
    bus.count = IM'(cnt);
    if (wr_now) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = IM'(wa);
      bus.wr_data = wd;
      mdl_mem[wa] = wd;
    end
    tick();
    bus.go    = 1'b0;
    bus.wr_en = 1'b0;
    bus.count = IM'($urandom);
    last = (cnt == 0) ? 1 : cnt + 2;
    for (int t = 0; t <= last; t++) begin
      if (cnt == 0) begin
        exp_start = 1'b0;
        exp_done  = (t == 0);
        exp_busy  = (t == 0);
      end else begin
        exp_start = (t >= 1) && (t <= cnt);
        exp_done  = (t == cnt + 1);
        exp_busy  = (t <= cnt + 1);
      end
      exp_data = exp_start ? mdl_mem[t-1] : '0;
      chk($sformatf("%s.t%0d.start", tag, t), {31'd0, bus.start}, {31'd0, exp_start});
      chk($sformatf("%s.t%0d.datain", tag, t), bus.datain, exp_data);
      chk($sformatf("%s.t%0d.done", tag, t), {31'd0, bus.done}, {31'd0, exp_done});
      chk($sformatf("%s.t%0d.busy", tag, t), {31'd0, bus.busy}, {31'd0, exp_busy});
      chk($sformatf("%s.t%0d.n", tag, t), {27'd0, bus.n}, cnt[DL-1:0]);
      if (t == inj) begin
        bus.go      = 1'b1;
        bus.count   = 5'd2;
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = '0;
      end else begin
        bus.go    = 1'b0;
        bus.wr_en = 1'b0;
      end
      tick();
    end
    bus.go    = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    logic [DL-1:0] w;
    int c;
    n_checks = 0;
    n_errors = 0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.go      = 1'b0;
    bus.count   = '0;
    tick();
    tick();
    chk_idle_zero("reset");
    chk("reset.wr_err", {31'd0, bus.wr_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Four identical words.
    for (int i = 0; i < 4; i++) wr(i, 32'h3f800000);
    run_stream("ones4", 4, 1'b0, 0, '0, -1);

    // Three distinct words then idle stream output.
    wr(0, 32'h3f800000);
    wr(1, 32'h40000000);
    wr(2, 32'h40400000);
    run_stream("seq3", 3, 1'b0, 0, '0, -1);

    // Zero-length request.
    run_stream("cnt0", 0, 1'b0, 0, '0, -1);

    // Random buffer and random lengths.
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
    for (int r = 0; r < 3; r++) begin
      c = $urandom_range(31, 1);
      run_stream($sformatf("rnd%0d", r), c, 1'b0, 0, '0, -1);
    end

    // Go and write on the same idle edge: the stream sees the new word.
    w = $urandom;
    run_stream("gowr", 2, 1'b1, 0, w, -1);

    // Write and go while busy are ignored; error flag sticks.
    run_stream("busywr", 8, 1'b0, 0, '0, 3);
    chk("busywr.wr_err", {31'd0, bus.wr_err}, 32'd1);
    run_stream("busywr.readback", 1, 1'b0, 0, '0, -1);
    chk("busywr.wr_err_sticky", {31'd0, bus.wr_err}, 32'd1);

    // Reset mid-stream, then replay untouched buffer.
    bus.go    = 1'b1;
    bus.count = 5'd8;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst.word2.start", {31'd0, bus.start}, 32'd1);
    chk("midrst.word2.datain", bus.datain, mdl_mem[2]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("midrst");
    chk("midrst.wr_err", {31'd0, bus.wr_err}, 32'd0);
    run_stream("replay", 8, 1'b0, 0, '0, -1);

    // Maximum length with buffer[i]=i: no wrap to 31 or 0.
    for (int i = 0; i < DEPTH; i++) wr(i, i[DL-1:0]);
    run_stream("max31", 31, 1'b0, 0, '0, -1);

    // Reset on the same edge as go and a write: reset wins.
    bus.go      = 1'b1;
    bus.count   = 5'd4;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'hdeadbeef;
    rst         = 1'b1;
    tick();
    rst       = 1'b0;
    bus.go    = 1'b0;
    bus.wr_en = 1'b0;
    chk_idle_zero("rstprio");
    run_stream("rstprio.readback", 2, 1'b0, 0, '0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/softmax_stream_tx.md
SOFTMAX_STREAM_TX -- requirements
Module: softmax_stream_tx

Interface
REQ-001 The block SHALL have parameter DATALENGTH, default 32, giving the float word width.
REQ-002 The block SHALL have parameter INPUTMAX, default 5, giving the count/address width; buffer depth = 2^INPUTMAX.
REQ-003 Port Clock  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port WrEn  input  1  buffer write strobe.
REQ-006 Port WrAddr  input  INPUTMAX  buffer write address.
REQ-007 Port WrData  input  DATALENGTH  IEEE-754 single word to store.
REQ-008 Port Go  input  1  request to transmit a vector.
REQ-009 Port Count  input  INPUTMAX  number of elements to transmit; sampled with Go.
REQ-010 Port Start  output  1  stream-valid toward the softmax consumer; high for exactly the element cycles.
REQ-011 Port Datain  output  DATALENGTH  stream word toward the softmax consumer.
REQ-012 Port N  output  INPUTMAX  element count toward the softmax consumer.
REQ-013 Port Busy  output  1  high while not IDLE.
REQ-014 Port Done  output  1  one-cycle pulse at end of transmission.
REQ-015 Port WrErr  output  1  sticky flag: write attempted while Busy.

Function
REQ-016 The buffer SHALL be 2^INPUTMAX x DATALENGTH; WrEn in IDLE SHALL write WrData to WrAddr on that edge.
REQ-017 WrEn while Busy SHALL not modify the buffer and SHALL set WrErr, which stays set until Reset.
REQ-018 The FSM SHALL have states IDLE, STREAM, FINISH.
REQ-019 IDLE: Go=1 with Count>0 SHALL latch Count into N, clear the read index, move to STREAM.
REQ-020 IDLE: Go=1 with Count=0 SHALL latch N=0, move to FINISH, and never assert Start.
REQ-021 STREAM: each cycle Start=1 and Datain=buffer[index]; index increments; after Count words move to FINISH.
REQ-022 Latency: Go sampled at edge k SHALL give Start=1, Datain=buffer[0] after edge k+1; word i after edge k+1+i.
REQ-023 Start SHALL be contiguous (no gaps), exactly N cycles long, and low after edge k+1+N.
REQ-024 FINISH SHALL last one cycle with Done=1, Start=0, then return to IDLE.
REQ-025 Go while Busy SHALL be ignored (no restart, no queuing).
REQ-026 Go and WrEn on the same IDLE edge: the write SHALL complete, and the stream SHALL use the new value.
REQ-027 Count=2^INPUTMAX-1 SHALL stream addresses 0..Count-1; the index SHALL never wrap within a stream.
REQ-028 Datain SHALL be 0 whenever Start=0.
REQ-029 N SHALL hold its latched value from Go until the next accepted Go.

Reset
REQ-030 Reset=1 at an edge SHALL force IDLE, Start=0, Datain=0, N=0, Busy=0, Done=0, WrErr=0, index=0, including mid-STREAM.
REQ-031 Reset SHALL not clear buffer contents; Reset takes priority over Go and WrEn on the same edge.

Verification
REQ-032 Write 3f800000 to addr 0..3; Go with Count=4 -> Start high 4 cycles starting the cycle after Go, Datain=3f800000 each cycle, N=4, Done pulse next cycle.
REQ-033 Write 3f800000, 40000000, 40400000 to addr 0..2; Count=3 -> Datain sequence 3f800000, 40000000, 40400000, then Start=0, Datain=0.
REQ-034 Go with Count=0 -> Start never high, Done pulses after one cycle, Busy high exactly 1 cycle.
REQ-035 Start a Count=8 stream; assert Go and WrEn (addr 0, data 0) at cycle 3 -> stream unchanged, buffer[0] unchanged, WrErr=1.
REQ-036 Assert Reset at stream word 2 -> the next cycle has Start=0, N=0, Busy=0, and a later Go replays the original buffer data.
REQ-037 Count=31 with buffer[i]=i -> 31 contiguous words 0..30, no wrap to 31 or 0.
